// File: rtl/oem_frame_collector.sv
// oem_frame_collector: captures odd/even bank byte writes into an 8-bank frame
// buffer, then streams the whole frame bank-major over valid/ready with a checksum.
module oem_frame_collector #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [DATA_W-1:0]   i_oem_dataout,
    input  logic [ADDR_W-1:0]   i_oem_addr,
    input  logic                i_odd1_wr,
    input  logic                i_odd2_wr,
    input  logic                i_odd3_wr,
    input  logic                i_odd4_wr,
    input  logic                i_even1_wr,
    input  logic                i_even2_wr,
    input  logic                i_even3_wr,
    input  logic                i_even4_wr,
    input  logic                i_oem_finish,
    input  logic                i_out_ready,
    output logic                o_out_valid,
    output logic [DATA_W-1:0]   o_out_data,
    output logic [ADDR_W+2:0]   o_out_index,
    output logic                o_out_last,
    output logic                o_done,
    output logic [15:0]         o_checksum,
    output logic [8:0]          o_wr_count,
    output logic                o_err_multi,
    output logic                o_err_count
);
    // state     | meaning
    // S_COLLECT | capture strobed writes until oem_finish
    // S_STREAM  | emit every buffer location over valid/ready
    // S_DONE    | all bytes accepted; idle until reset
    localparam int IDX_W = ADDR_W + 3;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {S_COLLECT, S_STREAM, S_DONE} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_written;
    logic [IDX_W:0]      r_rd_ptr;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [IDX_W-1:0]    r_out_index;
    logic                r_out_last;
    logic                r_done;
    logic [15:0]         r_checksum;
    logic [8:0]          r_wr_count;
    logic                r_err_multi;
    logic                r_err_count;

    logic [7:0]          w_strb;
    logic                w_any;
    logic                w_one;
    logic                w_multi;
    logic [2:0]          w_bank;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [8:0]          w_cnt_next;
    logic                w_accept;
    logic                w_load;

    // Bit position of each strobe is its bank number.
    assign w_strb = {i_even4_wr, i_odd4_wr, i_even3_wr, i_odd3_wr,
                     i_even2_wr, i_odd2_wr, i_even1_wr, i_odd1_wr};
    assign w_any   = |w_strb;
    assign w_one   = w_any && ((w_strb & (w_strb - 8'd1)) == 8'd0);
    assign w_multi = w_any && !w_one;

    always_comb begin
        w_bank = '0;
        for (int b = 0; b < 8; b++) begin
            if (w_strb[b]) w_bank = 3'(b);
        end
    end

    assign w_wr_idx   = {w_bank, i_oem_addr};
    assign w_rd_idx   = r_rd_ptr[IDX_W-1:0];
    assign w_cnt_next = (w_one && r_wr_count != 9'h1FF) ? r_wr_count + 9'd1 : r_wr_count;
    assign w_accept   = r_out_valid && i_out_ready;
    assign w_load     = (!r_out_valid || i_out_ready) && !r_rd_ptr[IDX_W];

    // Buffer is deliberately not reset; r_written masks stale contents.
    always_ff @(posedge i_clk) begin
        if (!i_reset && r_state == S_COLLECT && w_one) begin
            r_mem[w_wr_idx] <= i_oem_dataout;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_COLLECT;
            r_written   <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
            r_wr_count  <= '0;
            r_err_multi <= 1'b0;
            r_err_count <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_one) r_written[w_wr_idx] <= 1'b1;
                    if (w_multi) r_err_multi <= 1'b1;
                    r_wr_count <= w_cnt_next;
                    if (i_oem_finish) begin
                        r_state <= S_STREAM;
                        if (w_cnt_next != 9'(DEPTH)) r_err_count <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_any) r_err_count <= 1'b1;
                    if (w_accept) r_checksum <= r_checksum + 16'(r_out_data);
                    if (w_accept && r_out_last) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_out_valid <= 1'b0;
                    end else if (w_load) begin
                        r_out_data  <= r_written[w_rd_idx] ? r_mem[w_rd_idx] : '0;
                        r_out_index <= w_rd_idx;
                        r_out_last  <= (r_rd_ptr == (IDX_W+1)'(DEPTH - 1));
                        r_out_valid <= 1'b1;
                        r_rd_ptr    <= r_rd_ptr + 1'b1;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (w_any) r_err_count <= 1'b1;
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_index = r_out_index;
    assign o_out_last  = r_out_last;
    assign o_done      = r_done;
    assign o_checksum  = r_checksum;
    assign o_wr_count  = r_wr_count;
    assign o_err_multi = r_err_multi;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_oem_frame_collector.sv
// Bench for oem_frame_collector: randomized writes and ready patterns compared
// against a frame-level model (written map + byte array + counters).
module tb_oem_frame_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic [4:0] addr = '0;
    logic [7:0] strb = '0;
    logic       fin = 1'b0;
    logic       rdy = 1'b0;

    logic       o_out_valid;
    logic [7:0] o_out_data;
    logic [7:0] o_out_index;
    logic       o_out_last;
    logic       o_done;
    logic [15:0] o_checksum;
    logic [8:0] o_wr_count;
    logic       o_err_multi;
    logic       o_err_count;

    always #5 clk = ~clk;

    oem_frame_collector #(.DATA_W(8), .ADDR_W(5)) dut (
        .i_clk(clk), .i_reset(rst), .i_oem_dataout(din), .i_oem_addr(addr),
        .i_odd1_wr(strb[0]), .i_even1_wr(strb[1]), .i_odd2_wr(strb[2]), .i_even2_wr(strb[3]),
        .i_odd3_wr(strb[4]), .i_even3_wr(strb[5]), .i_odd4_wr(strb[6]), .i_even4_wr(strb[7]),
        .i_oem_finish(fin), .i_out_ready(rdy),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_index(o_out_index),
        .o_out_last(o_out_last), .o_done(o_done), .o_checksum(o_checksum),
        .o_wr_count(o_wr_count), .o_err_multi(o_err_multi), .o_err_count(o_err_count)
    );

    int checks = 0;
    int errors = 0;

    // Frame model: what the sink should see once streaming starts.
    logic [7:0] m_mem [256];
    bit         m_wr  [256];
    int         m_cnt;
    bit         m_em;
    bit         m_ec;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        foreach (m_wr[i]) m_wr[i] = 1'b0;
        m_cnt = 0;
        m_em  = 1'b0;
        m_ec  = 1'b0;
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        return m_wr[i] ? m_mem[i] : 8'h00;
    endfunction

    function automatic logic [15:0] exp_sum();
        int s = 0;
        for (int i = 0; i < 256; i++) s += int'(exp_byte(i));
        return s[15:0];
    endfunction

    task automatic do_reset;
        rst = 1'b1; strb = '0; fin = 1'b0; rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic write_cycle(input logic [7:0] s, input logic [4:0] a, input logic [7:0] d);
        int bank = 0;
        din = d; addr = a; strb = s;
        if ($onehot(s)) begin
            for (int b = 0; b < 8; b++) if (s[b]) bank = b;
            m_mem[bank * 32 + int'(a)] = d;
            m_wr[bank * 32 + int'(a)]  = 1'b1;
            if (m_cnt < 511) m_cnt++;
        end else if (s != 8'h00) begin
            m_em = 1'b1;
        end
        tick();
        strb = '0;
    endtask

    task automatic random_write(input bit allow_bad);
        logic [7:0] s;
        int r = $urandom_range(0, 9);
        if (allow_bad && r == 0) s = 8'h00;
        else if (allow_bad && r == 1) s = 8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7));
        else s = 8'(1 << $urandom_range(0, 7));
        write_cycle(s, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    endtask

    task automatic do_finish;
        fin = 1'b1;
        if (m_cnt != 256) m_ec = 1'b1;
        tick();
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 random ready.
    // Returns early (before reset) when index stop_idx is presented.
    task automatic run_stream(input int mode, input int stop_idx, input int strobe_at);
        int acc = 0;
        int cyc = 0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [7:0] pd = '0, pi = '0;
        checks++;
        if (o_out_valid !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL stream_entry valid=%b done=%b required 0 0", o_out_valid, o_done);
        end
        while (acc < 256 && cyc < 3000) begin
            if (stop_idx >= 0 && o_out_valid === 1'b1 && int'(o_out_index) == stop_idx) return;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                checks++;
                if (o_out_valid !== 1'b1 || o_out_data !== pd || o_out_index !== pi || o_out_last !== pl) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h i=%0d l=%b required v=1 d=%h i=%0d l=%b",
                             o_out_valid, o_out_data, o_out_index, o_out_last, pd, pi, pl);
                end
            end
            if (o_out_valid === 1'b1 && rdy) begin
                checks++;
                if (o_out_index !== 8'(acc) || o_out_data !== exp_byte(acc) || o_out_last !== (acc == 255)) begin
                    errors++;
                    $display("FAIL stream_byte got i=%0d d=%h l=%b required i=%0d d=%h l=%b",
                             o_out_index, o_out_data, o_out_last, acc, exp_byte(acc), acc == 255);
                end
                if (acc == 255) begin
                    checks++;
                    if (o_done !== 1'b0) begin
                        errors++;
                        $display("FAIL done_early got %b required 0", o_done);
                    end
                end
                if (acc == strobe_at) begin
                    strb = 8'h01; addr = 5'd7; din = 8'hEE;
                    m_ec = 1'b1;
                end
                acc++;
            end
            pv = o_out_valid; pr = rdy; pd = o_out_data; pi = o_out_index; pl = o_out_last;
            tick();
            strb = '0;
            cyc++;
        end
        checks++;
        if (acc != 256) begin
            errors++;
            $display("FAIL stream_timeout got %0d accepts required 256", acc);
        end
        if (mode == 0) begin
            checks++;
            if (cyc != 257) begin
                errors++;
                $display("FAIL throughput got %0d cycles required 257", cyc);
            end
        end
        checks++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0 || o_checksum !== exp_sum()) begin
            errors++;
            $display("FAIL done_state got done=%b valid=%b sum=%h required 1 0 %h",
                     o_done, o_out_valid, o_checksum, exp_sum());
        end
        checks++;
        if (o_wr_count !== 9'(m_cnt) || o_err_multi !== m_em || o_err_count !== m_ec) begin
            errors++;
            $display("FAIL counters got cnt=%0d em=%b ec=%b required %0d %b %b",
                     o_wr_count, o_err_multi, o_err_count, m_cnt, m_em, m_ec);
        end
        rdy = 1'b1; fin = 1'b0;
        tick();
        tick();
        checks++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0 || o_checksum !== exp_sum()) begin
            errors++;
            $display("FAIL done_sticky got done=%b valid=%b sum=%h", o_done, o_out_valid, o_checksum);
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({o_out_valid, o_out_last, o_done, o_err_multi, o_err_count} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 00000",
                     {o_out_valid, o_out_last, o_done, o_err_multi, o_err_count});
        end
        checks++;
        if (o_out_data !== 8'h00 || o_out_index !== 8'h00 || o_checksum !== 16'h0 || o_wr_count !== 9'h0) begin
            errors++;
            $display("FAIL reset_values got d=%h i=%h sum=%h cnt=%0d required zeros",
                     o_out_data, o_out_index, o_checksum, o_wr_count);
        end
    endtask

    task automatic test_full_frame(input int mode);
        do_reset();
        for (int i = 0; i < 256; i++) write_cycle(8'(1 << (i / 32)), 5'(i % 32), 8'(i));
        do_finish();
        run_stream(mode, -1, -1);
        checks++;
        if (o_checksum !== 16'h7F80 || o_err_count !== 1'b0 || o_err_multi !== 1'b0) begin
            errors++;
            $display("FAIL full_frame got sum=%h ec=%b em=%b required 7f80 0 0",
                     o_checksum, o_err_count, o_err_multi);
        end
    endtask

    task automatic test_single;
        do_reset();
        write_cycle(8'h01, 5'd3, 8'hA5);
        do_finish();
        run_stream(2, -1, -1);
        checks++;
        if (o_checksum !== 16'h00A5 || o_err_count !== 1'b1) begin
            errors++;
            $display("FAIL single_write got sum=%h ec=%b required 00a5 1", o_checksum, o_err_count);
        end
    endtask

    task automatic test_multi;
        do_reset();
        write_cycle(8'h10, 5'd9, 8'h3C);
        write_cycle(8'h0C, 5'd0, 8'h5A);
        checks++;
        if (o_wr_count !== 9'd1 || o_err_multi !== 1'b1 || o_err_count !== 1'b0) begin
            errors++;
            $display("FAIL multi_strobe got cnt=%0d em=%b ec=%b required 1 1 0",
                     o_wr_count, o_err_multi, o_err_count);
        end
        do_finish();
        run_stream(1, -1, -1);
    endtask

    task automatic test_random(input int n);
        do_reset();
        repeat (n) random_write(1'b1);
        do_finish();
        run_stream(2, -1, -1);
    endtask

    task automatic test_saturate;
        do_reset();
        repeat (520) random_write(1'b0);
        checks++;
        if (o_wr_count !== 9'd511) begin
            errors++;
            $display("FAIL wr_count_sat got %0d required 511", o_wr_count);
        end
        do_finish();
        run_stream(0, -1, -1);
    endtask

    task automatic test_midstream;
        do_reset();
        repeat (40) random_write(1'b0);
        do_finish();
        run_stream(0, 100, 10);
        checks++;
        if (o_out_valid !== 1'b1 || o_out_index !== 8'd100 || o_err_count !== 1'b1) begin
            errors++;
            $display("FAIL mid_stream got v=%b i=%0d ec=%b required 1 100 1",
                     o_out_valid, o_out_index, o_err_count);
        end
        test_reset();
        repeat (5) random_write(1'b0);
        do_finish();
        run_stream(2, -1, -1);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_full_frame(0);
        test_full_frame(1);
        test_single();
        test_multi();
        test_random(200);
        test_random(300);
        test_saturate();
        test_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
